// File: rtl/systolic_seq_ctrl.sv
// Job sequencer for a SIZE x SIZE systolic pe_array computing C = A(SIZExK) * B(KxSIZE).
// Walks the shared A/B buffer address, skews the read data diagonally onto the array edges,
// clears the accumulators up front, drains the pipeline and reports the job length in cycles.
module systolic_seq_ctrl #(
  parameter int unsigned SIZE   = 4,
  parameter int unsigned K_MAX  = 256,
  parameter int unsigned PE_LAT = 1,
  localparam int unsigned AW    = $clog2(K_MAX)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [AW:0]         k_len,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic                rd_en,
  output logic [AW-1:0]       rd_addr,
  input  logic [SIZE*8-1:0]   a_rd_data,
  input  logic [SIZE*8-1:0]   b_rd_data,
  output logic                pe_acc_clr,
  output logic [SIZE*8-1:0]   a_feed,
  output logic [SIZE*8-1:0]   b_feed,
  output logic [31:0]         busy_cycles
);

  localparam int unsigned KW = AW + 1;
  localparam int unsigned D  = 2 * (SIZE - 1) + PE_LAT + 1;
  localparam int unsigned FW = (D > 1) ? $clog2(D + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t          state;
  logic [KW-1:0]   klen_q;
  logic [KW-1:0]   n_q;
  logic [FW-1:0]   fl_q;
  logic [31:0]     cyc_q;

  logic              in_job_c;
  logic              skew_clr_c;
  logic              feed_vld_c;
  logic [KW:0]       n_plus2_c;
  logic [SIZE*8-1:0] a_in_c;
  logic [SIZE*8-1:0] b_in_c;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Job-phase decode, skew flush condition and gated edge inputs
  always_comb begin
    in_job_c   = (state == S_CLEAR) || (state == S_FEED) || (state == S_FLUSH);
    skew_clr_c = rst || (abort && in_job_c);
    feed_vld_c = (state == S_FEED);
    n_plus2_c  = {1'b0, n_q} + (KW + 1)'(2);
    a_in_c     = feed_vld_c ? a_rd_data : '0;
    b_in_c     = feed_vld_c ? b_rd_data : '0;
  end

  // Sequencer FSM with registered control outputs and cycle accounting
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      rd_en       <= 1'b0;
      rd_addr     <= '0;
      pe_acc_clr  <= 1'b0;
      busy_cycles <= '0;
      klen_q      <= '0;
      n_q         <= '0;
      fl_q        <= '0;
      cyc_q       <= '0;
    end else begin
      done       <= 1'b0;
      pe_acc_clr <= 1'b0;
      if (in_job_c && abort) begin
        state   <= S_IDLE;
        busy    <= 1'b0;
        rd_en   <= 1'b0;
        rd_addr <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              state      <= S_CLEAR;
              klen_q     <= k_len;
              busy       <= 1'b1;
              pe_acc_clr <= 1'b1;
              rd_en      <= (k_len != '0);
              rd_addr    <= '0;
              cyc_q      <= 32'd1;
            end
          end
          S_CLEAR: begin
            cyc_q <= sat_inc(cyc_q);
            n_q   <= '0;
            fl_q  <= '0;
            if (klen_q == '0) begin
              state <= S_FLUSH;
              rd_en <= 1'b0;
            end else begin
              state   <= S_FEED;
              rd_en   <= (klen_q > KW'(1));
              rd_addr <= AW'(1);
            end
          end
          S_FEED: begin
            cyc_q <= sat_inc(cyc_q);
            if (n_q == klen_q - KW'(1)) begin
              state   <= S_FLUSH;
              rd_en   <= 1'b0;
              rd_addr <= '0;
            end else begin
              n_q     <= n_q + KW'(1);
              rd_en   <= (n_plus2_c < {1'b0, klen_q});
              rd_addr <= AW'(n_plus2_c);
            end
          end
          S_FLUSH: begin
            if (fl_q == FW'(D - 1)) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              fl_q  <= fl_q + FW'(1);
              cyc_q <= sat_inc(cyc_q);
            end
          end
          S_DONE: begin
            busy_cycles <= cyc_q;
            state       <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  for (genvar i = 0; i < SIZE; i++) begin : g_lane
    logic [8*(i+1)-1:0] a_sr;
    logic [8*(i+1)-1:0] b_sr;

    // Lane i delay line of 1+i stages; the last stage drives the array edge
    always_ff @(posedge clk) begin
      if (skew_clr_c) begin
        a_sr <= '0;
        b_sr <= '0;
      end else begin
        a_sr[7:0] <= a_in_c[8*i +: 8];
        b_sr[7:0] <= b_in_c[8*i +: 8];
        for (int j = 1; j <= i; j++) begin
          a_sr[8*j +: 8] <= a_sr[8*(j-1) +: 8];
          b_sr[8*j +: 8] <= b_sr[8*(j-1) +: 8];
        end
      end
    end

    assign a_feed[8*i +: 8] = a_sr[8*i +: 8];
    assign b_feed[8*i +: 8] = b_sr[8*i +: 8];
  end

endmodule
